// File: rtl/conv_addr_gen.sv
// Convolution window read-address generator: sweeps every k x k window of an
// output tile and streams one feature-map word address per valid/ready beat.
module conv_addr_gen #(
  parameter int AW   = 11,
  parameter int DIMW = 8,
  parameter int KW   = 3,
  parameter int SW   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW-1:0]   cfg_base,
  input  logic [AW-1:0]   cfg_pitch,
  input  logic [DIMW-1:0] cfg_out_w,
  input  logic [DIMW-1:0] cfg_out_h,
  input  logic [KW-1:0]   cfg_k,
  input  logic [SW-1:0]   cfg_stride,
  output logic [AW-1:0]   m_addr,
  output logic            m_addr_first,
  output logic            m_addr_last,
  output logic            m_addr_valid,
  input  logic            m_addr_ready,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t          state_q;
  logic [AW-1:0]   pitch_q, stride_q, row_step_q;
  logic [KW-1:0]   km1_q, kx_q, ky_q;
  logic [DIMW-1:0] wm1_q, hm1_q, ox_q, oy_q;
  logic [AW-1:0]   row_q, win_q, krow_q;
  logic [AW-1:0]   m_addr_q;
  logic            first_q, last_q, valid_q, busy_q, done_q;

  logic [KW-1:0]   kx_d, ky_d;
  logic [DIMW-1:0] ox_d, oy_d;
  logic [AW-1:0]   row_d, win_d, krow_d, addr_d;
  logic            first_d, last_d, final_beat;
  logic [AW-1:0]   row_step_cfg;
  logic            cfg_empty;

  assign m_addr       = m_addr_q;
  assign m_addr_first = first_q;
  assign m_addr_last  = last_q;
  assign m_addr_valid = valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

  assign cfg_empty = (cfg_out_w == '0) || (cfg_out_h == '0) || (cfg_k == '0);

  // Vertical window step stride*pitch, built by shift-and-add at start.
  always_comb begin
    row_step_cfg = '0;
    for (int b = 0; b < SW; b++) begin
      if (cfg_stride[b]) row_step_cfg = row_step_cfg + (cfg_pitch << b);
    end
  end

  // Next beat: innermost counter that is not at its maximum advances and the
  // address restarts from the base register one level above it.
  always_comb begin
    kx_d       = kx_q;
    ky_d       = ky_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    row_d      = row_q;
    win_d      = win_q;
    krow_d     = krow_q;
    addr_d     = m_addr_q;
    final_beat = 1'b0;
    if (kx_q != km1_q) begin
      kx_d   = kx_q + KW'(1);
      addr_d = m_addr_q + AW'(1);
    end else if (ky_q != km1_q) begin
      kx_d   = '0;
      ky_d   = ky_q + KW'(1);
      krow_d = krow_q + pitch_q;
      addr_d = krow_d;
    end else if (ox_q != wm1_q) begin
      kx_d   = '0;
      ky_d   = '0;
      ox_d   = ox_q + DIMW'(1);
      win_d  = win_q + stride_q;
      krow_d = win_d;
      addr_d = win_d;
    end else if (oy_q != hm1_q) begin
      kx_d   = '0;
      ky_d   = '0;
      ox_d   = '0;
      oy_d   = oy_q + DIMW'(1);
      row_d  = row_q + row_step_q;
      win_d  = row_d;
      krow_d = row_d;
      addr_d = row_d;
    end else begin
      final_beat = 1'b1;
    end
    first_d = (ky_d == '0) && (kx_d == '0);
    last_d  = (ky_d == km1_q) && (kx_d == km1_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pitch_q    <= '0;
      stride_q   <= '0;
      row_step_q <= '0;
      km1_q      <= '0;
      wm1_q      <= '0;
      hm1_q      <= '0;
      kx_q       <= '0;
      ky_q       <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      row_q      <= '0;
      win_q      <= '0;
      krow_q     <= '0;
      m_addr_q   <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            pitch_q    <= cfg_pitch;
            stride_q   <= AW'(cfg_stride);
            row_step_q <= row_step_cfg;
            km1_q      <= cfg_k - KW'(1);
            wm1_q      <= cfg_out_w - DIMW'(1);
            hm1_q      <= cfg_out_h - DIMW'(1);
            kx_q       <= '0;
            ky_q       <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            row_q      <= cfg_base;
            win_q      <= cfg_base;
            krow_q     <= cfg_base;
            m_addr_q   <= cfg_base;
            busy_q     <= 1'b1;
            if (cfg_empty) begin
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              first_q <= 1'b1;
              last_q  <= (cfg_k == KW'(1));
              valid_q <= 1'b1;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (valid_q && m_addr_ready) begin
            if (final_beat) begin
              valid_q <= 1'b0;
              first_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              kx_q     <= kx_d;
              ky_q     <= ky_d;
              ox_q     <= ox_d;
              oy_q     <= oy_d;
              row_q    <= row_d;
              win_q    <= win_d;
              krow_q   <= krow_d;
              m_addr_q <= addr_d;
              first_q  <= first_d;
              last_q   <= last_d;
            end
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_addr_gen.sv
// Scoreboard bench for conv_addr_gen: a loop-based address model fills the
// expected queue, an independent monitor checks every transferred beat.
module tb_conv_addr_gen;

  localparam int AW = 11, DIMW = 8, KW = 3, SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AW-1:0]   cfg_base, cfg_pitch;
  logic [DIMW-1:0] cfg_out_w, cfg_out_h;
  logic [KW-1:0]   cfg_k;
  logic [SW-1:0]   cfg_stride;
  logic [AW-1:0]   m_addr;
  logic            m_addr_first, m_addr_last, m_addr_valid, m_addr_ready;
  logic            busy, done;

  conv_addr_gen #(.AW(AW), .DIMW(DIMW), .KW(KW), .SW(SW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_base(cfg_base), .cfg_pitch(cfg_pitch),
    .cfg_out_w(cfg_out_w), .cfg_out_h(cfg_out_h),
    .cfg_k(cfg_k), .cfg_stride(cfg_stride),
    .m_addr(m_addr), .m_addr_first(m_addr_first), .m_addr_last(m_addr_last),
    .m_addr_valid(m_addr_valid), .m_addr_ready(m_addr_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic          f;
    logic          l;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    rmode    = 0;
  int    sweep_id = 0;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  // Reference: direct formula over the four nested loops.
  function automatic int push_model(input int b, input int p, input int w,
                                    input int h, input int k, input int s);
    int cnt = 0;
    for (int oy = 0; oy < h; oy++)
      for (int ox = 0; ox < w; ox++)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++) begin
            logic [31:0] full;
            beat_t e;
            full = 32'(b + (oy * s + ky) * p + ox * s + kx);
            e.a  = full[AW-1:0];
            e.f  = (ky == 0) && (kx == 0);
            e.l  = (ky == k - 1) && (kx == k - 1);
            exp_q.push_back(e);
            cnt++;
          end
    return cnt;
  endfunction

  // Ready pattern: 0 = always, 1 = 1,0,0 repeating, 2 = random.
  initial begin
    int ph = 0;
    m_addr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1:       m_addr_ready = (ph % 3 == 0);
        2:       m_addr_ready = 1'($urandom_range(0, 1));
        default: m_addr_ready = 1'b1;
      endcase
      ph++;
    end
  end

  // Monitor: pops the scoreboard on every transfer, checks hold under stall.
  initial begin
    bit    prev_stall = 1'b0;
    beat_t prev_b;
    beat_t got;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        continue;
      end
      got = '{a: m_addr, f: m_addr_first, l: m_addr_last};
      if (prev_stall)
        check(m_addr_valid && (got == prev_b), "hold_stable",
              {m_addr_valid, 18'(got)}, {1'b1, 18'(prev_b)});
      if (m_addr_valid && m_addr_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_beat", 32'(got), 32'h0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check(got == e, "beat_addr_first_last", 32'(got), 32'(e));
        end
      end
      prev_stall = m_addr_valid && !m_addr_ready;
      prev_b     = got;
    end
  end

  task automatic scramble_cfg();
    cfg_base   = AW'($urandom);
    cfg_pitch  = AW'($urandom);
    cfg_out_w  = DIMW'($urandom_range(0, 5));
    cfg_out_h  = DIMW'($urandom_range(0, 5));
    cfg_k      = KW'($urandom);
    cfg_stride = SW'($urandom);
  endtask

  // Called at posedge+1; returns at posedge+1 after the sweep completes.
  task automatic run_sweep(input int b, input int p, input int w, input int h,
                           input int k, input int s, input int mode, input bit midstart);
    int  beats;
    int  n = 0;
    bit  got_done = 1'b0;
    rmode      = mode;
    cfg_base   = AW'(b);
    cfg_pitch  = AW'(p);
    cfg_out_w  = DIMW'(w);
    cfg_out_h  = DIMW'(h);
    cfg_k      = KW'(k);
    cfg_stride = SW'(s);
    start      = 1'b1;
    beats      = push_model(b, p, w, h, k, s);
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble_cfg();
    while (!got_done && n < 4000) begin
      @(negedge clk);
      n++;
      if (n == 1)
        check(m_addr_valid == (beats > 0), "first_beat_latency", 32'(m_addr_valid), 32'(beats > 0));
      if (midstart && n == 3) begin
        scramble_cfg();
        start = 1'b1;
      end
      if (midstart && n == 4) start = 1'b0;
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    check(got_done, "done_seen", 32'(got_done), 32'h1);
    if (mode == 0) check(n == beats + 1, "done_timing", 32'(n), 32'(beats + 1));
    check(exp_q.size() == 0, "all_beats_seen", 32'(exp_q.size()), 32'h0);
    check(!m_addr_valid && busy, "valid_busy_at_done", {m_addr_valid, busy}, 2'b01);
    exp_q.delete();
    @(negedge clk);
    check(!busy && !done, "busy_done_clear", {busy, done}, 2'b00);
    $display("sweep %0d: base=0x%0h pitch=%0d w=%0d h=%0d k=%0d s=%0d mode=%0d beats=%0d cycles=%0d",
             sweep_id, b, p, w, h, k, s, mode, beats, n);
    sweep_id++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    cfg_base = '0; cfg_pitch = '0; cfg_out_w = '0; cfg_out_h = '0; cfg_k = '0; cfg_stride = '0;
    #1;
    check(m_addr == '0, "reset_addr", 32'(m_addr), 32'h0);
    check({m_addr_first, m_addr_last, m_addr_valid} == 3'b000, "reset_flags_valid",
          {m_addr_first, m_addr_last, m_addr_valid}, 3'b000);
    check({busy, done} == 2'b00, "reset_busy_done", {busy, done}, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_sweep(12'h100, 8, 2, 1, 2, 1, 0, 1'b0);   // basic
    run_sweep(12'h100, 8, 2, 1, 2, 1, 1, 1'b1);   // backpressure + start while busy
    run_sweep(0, 16, 2, 2, 1, 2, 0, 1'b0);        // stride/rows, k=1
    run_sweep(12'h7FE, 1, 1, 1, 2, 1, 0, 1'b0);   // wrap-around
    run_sweep(12'h055, 3, 0, 2, 2, 1, 0, 1'b0);   // out_w = 0
    run_sweep(12'h055, 3, 2, 2, 0, 1, 0, 1'b0);   // k = 0
    run_sweep(12'h200, 5, 3, 2, 2, 0, 2, 1'b0);   // stride = 0

    // Async reset at beat 3 of a sweep.
    rmode      = 0;
    cfg_base   = 11'h100; cfg_pitch = 11'd8; cfg_out_w = 8'd2; cfg_out_h = 8'd1;
    cfg_k      = 3'd2;    cfg_stride = 2'd1;
    start      = 1'b1;
    void'(push_model(11'h100, 8, 2, 1, 2, 1));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check({m_addr_valid, busy, done} == 3'b000, "async_reset_mid_sweep",
          {m_addr_valid, busy, done}, 3'b000);
    check(m_addr == '0, "async_reset_addr", 32'(m_addr), 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    begin
      bit quiet = 1'b1;
      repeat (4) begin
        @(negedge clk);
        if (done || m_addr_valid || busy) quiet = 1'b0;
      end
      check(quiet, "no_done_after_reset", 32'(quiet), 32'h1);
    end
    @(posedge clk);
    #1;
    run_sweep(12'h100, 8, 2, 1, 2, 1, 0, 1'b0);

    run_sweep(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)), 2, 1, 7,
              int'($urandom_range(0, 3)), 2, 1'b0);
    for (int i = 0; i < 8; i++)
      run_sweep(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                int'($urandom_range(1, 4)), int'($urandom_range(1, 3)),
                int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
